gray_fifo: RTL and testbench
============================

// Module: gray_fifo
// PURPOSE
//  Single-clock FIFO with Gray-coded read/write pointers and status flags.
//  - Stores WIDTH-bit words; flags full/empty; overflow/underflow error pulses.
//  - Used as a buffering stage and as the reference model for the pointer
//    logic of the later dual-clock variant.
//  - Gray pointers are kept so that only the synchronizers need adding later.
// PARAMETERS
//  WIDTH      8                data word width in bits
//  DEPTH      8                number of entries; must be a power of 2, >= 2
//  PTR_WIDTH  $clog2(DEPTH)    address bits; pointers are PTR_WIDTH+1 bits
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  wr_en      in   1      write request
//  wdata      in   WIDTH  write data, sampled with wr_en
//  rd_en      in   1      read request
//  rdata      out  WIDTH  registered read data
//  full       out  1      no free entry
//  empty      out  1      no stored entry
//  overflow   out  1      registered pulse: write attempted while full
//  underflow  out  1      registered pulse: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): pointers=0, rdata=0, overflow=0,
//    underflow=0 => empty=1, full=0. Memory contents are not reset.
//  - Pointers: binary wbin/rbin (PTR_WIDTH+1 b); wgray/rgray = bin ^ (bin>>1)
//    are registered alongside them. Memory address = bin[PTR_WIDTH-1:0].
//  - Write: wr_en && !full -> mem[waddr]<=wdata; wbin++ (wraps naturally).
//  - Read: rd_en && !empty -> rdata<=mem[raddr] (1-cycle latency); rbin++.
//    Otherwise rdata holds its last value.
//  - empty = (wgray == rgray), combinational from registered pointers.
//  - full  = (wgray == {~rgray[PTR_WIDTH:PTR_WIDTH-1], rgray[PTR_WIDTH-2:0]}).
//  - Flags use pre-edge state: simultaneous wr_en && rd_en while full ->
//    read done, write dropped, overflow=1. While empty -> write done, read
//    dropped, underflow=1. Otherwise both done; occupancy unchanged.
//  - overflow <= wr_en && full; underflow <= rd_en && empty. Each is updated
//    every cycle: it is high for exactly one cycle per rejected request and
//    cleared by reset.
//  - Rejected operations never move a pointer or corrupt memory.
//  - Reset mid-operation: reset wins; in-flight requests that cycle are
//    ignored; FIFO becomes empty.
//  - Data order is strict FIFO across any number of wrap-arounds.
// STRUCTURE
//  - Shared package: none required. Gray conversion is the only shared item;
//    put a bin2gray function there if other blocks need it.
//  - One sub-module: gray_ptr. Parameter PTR_WIDTH; ports clk, rst_n, inc;
//    outputs bin and gray. Instantiate it once for the write side and once
//    for the read side. Memory array and flag logic stay in the top level.
// TESTING  (DEPTH=8, WIDTH=8)
//  - Write 8 random words from reset -> full=1 after the 8th write;
//    empty=0; overflow=0.
//  - Write 13 words -> last 5 rejected; overflow=1 on each of those 5 cycles.
//    A following 8 reads return the first 8 words in order.
//  - Read 13 times from reset -> underflow=1 for all 13 cycles; empty stays 1;
//    rdata stays 0.
//  - Write 8 then read 8, twice -> data matches in order; empty=1 at end.
//    Wrap-around exercised; gray pointers return to 0.
//  - Full plus simultaneous wr/rd -> read returns oldest word, write dropped,
//    overflow=1, full drops to 0. Empty plus simultaneous wr/rd -> underflow=1,
//    empty drops to 0.
//  - Random concurrency: 19 writes and 15 reads with 0-5 idle cycles each.
//    Scoreboard all reads; no flag errors unless a flag was asserted.

Source files
------------

// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO family (single- and dual-clock variants).
package gray_fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// Binary/Gray pointer pair. The Gray copy is registered so that it can feed a
// synchronizer directly in the dual-clock variant.
module gray_ptr
  import gray_fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [PTR_WIDTH:0] bin,
  output logic [PTR_WIDTH:0] gray
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] bin_next;

  always_comb begin
    bin_next = bin + PW'(inc);
  end

  // Gray is derived from the next binary value, so both stay in step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= PW'(bin2gray(GRAY_MAX_W'(bin_next)));
    end
  end

endmodule

// File: rtl/gray_fifo.sv
// Single-clock FIFO with Gray-coded pointers, full/empty flags and registered
// overflow/underflow pulses. Reference for the dual-clock pointer logic.
module gray_fifo
  import gray_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wbin, wgray, rbin, rgray;
  logic               do_wr, do_rd;
  logic               unused_ptr_msb;

  always_comb begin
    do_wr          = wr_en && !full;
    do_rd          = rd_en && !empty;
    unused_ptr_msb = wbin[PTR_WIDTH] ^ rbin[PTR_WIDTH];
  end

  gray_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_wr),
    .bin   (wbin),
    .gray  (wgray)
  );

  gray_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_rd),
    .bin   (rbin),
    .gray  (rgray)
  );

  always_comb begin
    empty = (wgray == rgray);
  end

  // Full: Gray pointers differ only in their top two bits. With a 1-bit
  // address both pointer bits are "top" bits, so the whole word is inverted.
  if (PTR_WIDTH == 1) begin : g_full_w1
    always_comb begin
      full = (wgray == ~rgray);
    end
  end else begin : g_full_wn
    always_comb begin
      full = (wgray == {~rgray[PTR_WIDTH:PTR_WIDTH-1], rgray[PTR_WIDTH-2:0]});
    end
  end

  // Storage is not reset; a write during reset is ignored.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      mem[wbin[PTR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (do_rd) begin
        rdata <= mem[rbin[PTR_WIDTH-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_gray_fifo.sv
// Directed bench for gray_fifo (DEPTH=8, WIDTH=8) with a small queue scoreboard
// for the random-gap concurrency phase.
module tb_gray_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] rdata;
  logic       full, empty, overflow, underflow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  gray_fifo #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_rd;
  int unsigned wr_left, rd_left, gap;
  logic        pick_wr, exp_ov, exp_un;

  initial begin
    // Reset state
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    // 13 reads from empty: all rejected
    rd_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("rd13_unf", 32'(underflow), 32'd1);
      check("rd13_empty", 32'(empty), 32'd1);
      check("rd13_rdata", 32'(rdata), 32'd0);
    end
    rd_en = 1'b0;
    tick();
    check("rd13_unf_clr", 32'(underflow), 32'd0);

    // 13 writes: first 8 accepted, last 5 flagged as overflow
    wr_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wdata = 8'hA0 + 8'(i);
      tick();
      check("wr13_ovf", 32'(overflow), (i >= 8) ? 32'd1 : 32'd0);
      check("wr13_full", 32'(full), (i >= 7) ? 32'd1 : 32'd0);
      check("wr13_empty", 32'(empty), 32'd0);
    end
    idle_inputs();
    tick();
    check("wr13_ovf_clr", 32'(overflow), 32'd0);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("wr13_rdata", 32'(rdata), 32'hA0 + 32'(i));
      check("wr13_unf", 32'(underflow), 32'd0);
    end
    rd_en = 1'b0;
    check("wr13_drained", 32'(empty), 32'd1);

    // Write 8 / read 8 twice from reset: pointers travel 16 and wrap to 0
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        wdata = 8'(16 * pass + 3 * i + 1);
        tick();
      end
      wr_en = 1'b0;
      check("wrap_full", 32'(full), 32'd1);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tick();
        check("wrap_rdata", 32'(rdata), 32'(16 * pass + 3 * i + 1));
      end
      rd_en = 1'b0;
      check("wrap_empty", 32'(empty), 32'd1);
    end
    check("wrap_wgray", 32'(u_dut.wgray), 32'd0);
    check("wrap_rgray", 32'(u_dut.rgray), 32'd0);

    // Full with simultaneous write and read
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'h30 + 8'(i);
      tick();
    end
    check("fsim_pre_full", 32'(full), 32'd1);
    rd_en = 1'b1;
    wdata = 8'hFF;
    tick();
    check("fsim_rdata", 32'(rdata), 32'h30);
    check("fsim_ovf", 32'(overflow), 32'd1);
    check("fsim_full", 32'(full), 32'd0);
    check("fsim_unf", 32'(underflow), 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("fsim_drain", 32'(rdata), 32'h30 + 32'(i));
    end
    rd_en = 1'b0;
    check("fsim_empty", 32'(empty), 32'd1);

    // Empty with simultaneous write and read
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h5A;
    tick();
    check("esim_unf", 32'(underflow), 32'd1);
    check("esim_empty", 32'(empty), 32'd0);
    check("esim_ovf", 32'(overflow), 32'd0);
    check("esim_rdata_hold", 32'(rdata), 32'h37);
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    check("esim_rdata", 32'(rdata), 32'h5A);
    check("esim_empty_end", 32'(empty), 32'd1);

    // Reset while requests are in flight
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'hC0 + 8'(i);
      tick();
    end
    rd_en = 1'b1;
    tick();
    check("mid_rdata_pre", 32'(rdata), 32'hC0);
    rst_n = 1'b0;
    tick();
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_rdata", 32'(rdata), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    check("mid_unf", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();
    check("mid_empty_after", 32'(empty), 32'd1);

    // Random gaps: 19 writes, 15 reads, scoreboarded
    q.delete();
    wr_left = 19;
    rd_left = 15;
    while (wr_left + rd_left > 0) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < int'(gap); g++) tick();
      pick_wr = (rd_left == 0) || (wr_left > 0 && $urandom_range(0, 1) == 1);
      exp_ov = 1'b0;
      exp_un = 1'b0;
      if (pick_wr) begin
        wr_left--;
        wr_en = 1'b1;
        wdata = 8'($urandom);
        if (q.size() < 8) q.push_back(wdata);
        else exp_ov = 1'b1;
        tick();
        wr_en = 1'b0;
      end else begin
        rd_left--;
        rd_en = 1'b1;
        if (q.size() > 0) exp_rd = q.pop_front();
        else exp_un = 1'b1;
        tick();
        rd_en = 1'b0;
        if (!exp_un) check("rnd_rdata", 32'(rdata), 32'(exp_rd));
      end
      check("rnd_ovf", 32'(overflow), 32'(exp_ov));
      check("rnd_unf", 32'(underflow), 32'(exp_un));
      check("rnd_full", 32'(full), (q.size() == 8) ? 32'd1 : 32'd0);
      check("rnd_empty", 32'(empty), (q.size() == 0) ? 32'd1 : 32'd0);
    end
    // Remaining entries still come out in order
    while (q.size() > 0) begin
      exp_rd = q.pop_front();
      rd_en = 1'b1;
      tick();
      check("rnd_tail", 32'(rdata), 32'(exp_rd));
    end
    rd_en = 1'b0;
    check("rnd_end_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
